reg_file: RTL and testbench
===========================

Name: reg_file

Overview:
- 4-entry x 8-bit general register file for the pipelined processor's decode stage.
- Two asynchronous read ports and one synchronous write port.
- Register R3 doubles as the stack pointer (SP), with dedicated increment/decrement controls for PUSH/POP/CALL/RET.

Parameters:
- DATA_W, 8, register width in bits.
- NUM_REGS, 4, number of registers; address width is clog2(NUM_REGS) = 2.
- SP_IDX, 3, index of the register that acts as SP.
- SP_RST, 8'hFF, reset value of the SP register.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- WE  in  1  write enable for port W.
- IncSP  in  1  increment SP by 1 on next clock edge.
- DecSP  in  1  decrement SP by 1 on next clock edge.
- RA_addr  in  2  read port A address.
- RB_addr  in  2  read port B address.
- RW_addr  in  2  write port address.
- WD  in  DATA_W  write data.
- RD_A  out  DATA_W  read data A = file[RA_addr].
- RD_B  out  DATA_W  read data B = file[RB_addr].

Behaviour:
- Storage is array file[0..NUM_REGS-1]; hierarchical name "file" is kept for bench peeking.
- Reset: while rst=1, asynchronously R0..R2 <= 0 and R3 (SP) <= SP_RST. Reset overrides every other input, including mid-operation.
- Reads: purely combinational, zero latency. RD_A and RD_B follow address and register changes within the same cycle.
- Before a clock edge, a read of a register being written returns the old value.
- Both read ports may address the same register simultaneously.
- All updates happen on the rising edge of clk.
- Non-SP registers: when WE=1, file[RW_addr] <= WD.
- SP register priority, highest first:
  1. WE=1 and RW_addr==SP_IDX: SP <= WD. IncSP and DecSP are ignored.
  2. DecSP=1: SP <= SP-1, even if IncSP=1 at the same time.
  3. IncSP=1: SP <= SP+1.
  4. Otherwise SP holds its value.
- WE to a non-SP register while IncSP or DecSP is asserted: both updates occur in the same cycle.
- SP arithmetic is modulo 2^DATA_W: 0x00 decremented gives 0xFF; 0xFF incremented gives 0x00. No flags are produced.
- With WE=0, IncSP=0 and DecSP=0, all registers hold their values.
- Inputs are sampled only at the clock edge. No handshake and no state machine.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- When defined: write-through forwarding. If WE=1 and RA_addr==RW_addr, RD_A = WD combinationally; RD_B is forwarded the same way.
- Also when defined: if port A or B addresses SP_IDX and the SP is changing this cycle by IncSP/DecSP with no SP write, that port shows the SP value that will be stored at the next edge.
- When undefined: reads always return stored contents; there is no forwarding path.

Decomposition:
- Shared package regfile_pkg holds:
  - DATA_W, NUM_REGS, SP_IDX, SP_RST constants.
  - typedefs reg_addr_t (2 bits) and reg_data_t (8 bits).
- One sub-module is natural: sp_next_calc. It is combinational; inputs are current SP, WE, RW_addr, WD, IncSP and DecSP; output is next SP value. It encodes the priority and wrap rules and is reused by the bypass logic.

Test Plan:
- Reset check: assert rst=1 asynchronously mid-cycle with random prior contents -> R0..R2 = 0x00 and R3 = 0xFF immediately, without waiting for a clock edge.
- Write R0=0x11 and R3=0xFF, then RA=0, RB=3 -> RD_A=0x11, RD_B=0xFF without waiting for a clock edge.
- SP=0xFF, DecSP for 1 cycle -> 0xFE; then IncSP for 1 cycle -> 0xFF; then IncSP+DecSP together -> 0xFE (decrement wins).
- SP=0xFE, WE=1, RW_addr=3, WD=0xAA, IncSP=DecSP=1 -> SP=0xAA. Then an idle cycle -> SP stays 0xAA.
- Wrap and mixed write: SP=0x00 with DecSP -> 0xFF; SP=0xFF with IncSP -> 0x00. WE to R1 (WD=0x5A) with DecSP in the same cycle -> R1=0x5A and SP decremented.
- With REGFILE_BYPASS_EN defined: WE=1, RW=2, WD=0x3C, RA=2 -> RD_A=0x3C before the edge. With the macro undefined, RD_A shows the old R2 value until after the edge.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared sizes, reset value and types for the register file
package regfile_pkg;

  localparam int DATA_W   = 8;
  localparam int NUM_REGS = 4;
  localparam int ADDR_W   = $clog2(NUM_REGS);
  localparam int SP_IDX   = 3;
  localparam logic [DATA_W-1:0] SP_RST = 8'hFF;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/sp_next_calc.sv
// rtl/sp_next_calc.sv - next stack pointer value: explicit write, then decrement, then increment
module sp_next_calc
  import regfile_pkg::*;
(
  input  reg_data_t i_sp,
  input  logic      i_we,
  input  reg_addr_t i_rw_addr,
  input  reg_data_t i_wd,
  input  logic      i_inc,
  input  logic      i_dec,
  output reg_data_t o_sp_next
);

  logic w_sp_write;

  assign w_sp_write = i_we && (i_rw_addr == reg_addr_t'(SP_IDX));

  // Arithmetic wraps naturally at DATA_W bits; decrement beats increment.
  always_comb begin
    o_sp_next = i_sp;
    if (w_sp_write)
      o_sp_next = i_wd;
    else if (i_dec)
      o_sp_next = i_sp - reg_data_t'(1);
    else if (i_inc)
      o_sp_next = i_sp + reg_data_t'(1);
  end

endmodule

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 4x8 register file, two async read ports, one write port, R3 as stack pointer
// Optional write-through forwarding on the read ports when REGFILE_BYPASS_EN is defined.
module reg_file
  import regfile_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      WE,
  input  logic      IncSP,
  input  logic      DecSP,
  input  reg_addr_t RA_addr,
  input  reg_addr_t RB_addr,
  input  reg_addr_t RW_addr,
  input  reg_data_t WD,
  output reg_data_t RD_A,
  output reg_data_t RD_B
);

  reg_data_t file [NUM_REGS];
  reg_data_t w_sp_next;
  reg_data_t w_rd_a;
  reg_data_t w_rd_b;

  sp_next_calc u_sp_next_calc (
    .i_sp      (file[SP_IDX]),
    .i_we      (WE),
    .i_rw_addr (RW_addr),
    .i_wd      (WD),
    .i_inc     (IncSP),
    .i_dec     (DecSP),
    .o_sp_next (w_sp_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++)
        file[i] <= (i == SP_IDX) ? SP_RST : '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (i == SP_IDX)
          file[i] <= w_sp_next;
        else if (WE && (RW_addr == reg_addr_t'(i)))
          file[i] <= WD;
      end
    end
  end

  always_comb begin
    w_rd_a = file[RA_addr];
    w_rd_b = file[RB_addr];
`ifdef REGFILE_BYPASS_EN
    // SP reads show the value the edge will store; w_sp_next already covers an SP write.
    if (RA_addr == reg_addr_t'(SP_IDX))
      w_rd_a = w_sp_next;
    else if (WE && (RA_addr == RW_addr))
      w_rd_a = WD;
    if (RB_addr == reg_addr_t'(SP_IDX))
      w_rd_b = w_sp_next;
    else if (WE && (RB_addr == RW_addr))
      w_rd_b = WD;
`endif
  end

  assign RD_A = w_rd_a;
  assign RD_B = w_rd_b;

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - directed self-checking bench for reg_file
module tb_reg_file;

  logic       clk = 1'b0;
  logic       rst;
  logic       WE, IncSP, DecSP;
  logic [1:0] RA_addr, RB_addr, RW_addr;
  logic [7:0] WD;
  logic [7:0] RD_A, RD_B;

  int total = 0;
  int bad   = 0;
  logic [7:0] rnd [4];
  logic [7:0] exp_v;

  reg_file dut (
    .clk     (clk),
    .rst     (rst),
    .WE      (WE),
    .IncSP   (IncSP),
    .DecSP   (DecSP),
    .RA_addr (RA_addr),
    .RB_addr (RB_addr),
    .RW_addr (RW_addr),
    .WD      (WD),
    .RD_A    (RD_A),
    .RD_B    (RD_B)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    WE = 1'b0; IncSP = 1'b0; DecSP = 1'b0;
  endtask

  initial begin
    rst = 1'b1; idle(); RW_addr = 2'd0; WD = 8'h00;
    RA_addr = 2'd0; RB_addr = 2'd3;
    #3;
    check("rst_r0", RD_A, 8'h00);
    check("rst_r3", RD_B, 8'hFF);
    RA_addr = 2'd1; RB_addr = 2'd2; #1;
    check("rst_r1", RD_A, 8'h00);
    check("rst_r2", RD_B, 8'h00);

    // fill with random contents, then reset asynchronously mid-cycle
    tick(); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rnd[i] = 8'($urandom_range(1, 254));
      WE = 1'b1; RW_addr = 2'(i); WD = rnd[i];
      tick();
    end
    idle();
    RA_addr = 2'd0; RB_addr = 2'd3; #1;
    check("pre_rst_r0", RD_A, rnd[0]);
    check("pre_rst_r3", RD_B, rnd[3]);
    #2; rst = 1'b1; #1;
    for (int i = 0; i < 4; i++)
      check($sformatf("async_rst_r%0d", i), dut.file[i], (i == 3) ? 8'hFF : 8'h00);
    #1; rst = 1'b0;

    // R0=0x11, R3=0xFF
    tick();
    WE = 1'b1; RW_addr = 2'd0; WD = 8'h11; tick();
    RW_addr = 2'd3; WD = 8'hFF; tick();
    idle(); RA_addr = 2'd0; RB_addr = 2'd3; #1;
    check("rd_a_r0", RD_A, 8'h11);
    check("rd_b_r3", RD_B, 8'hFF);
    RA_addr = 2'd3; #1;
    check("same_addr_a", RD_A, 8'hFF);

    DecSP = 1'b1; tick(); idle();
    check("dec_sp", RD_B, 8'hFE);
    IncSP = 1'b1; tick(); idle();
    check("inc_sp", RD_B, 8'hFF);
    IncSP = 1'b1; DecSP = 1'b1; tick(); idle();
    check("inc_dec_sp", RD_B, 8'hFE);

    WE = 1'b1; RW_addr = 2'd3; WD = 8'hAA; IncSP = 1'b1; DecSP = 1'b1; tick(); idle();
    check("we_sp_prio", RD_B, 8'hAA);
    tick();
    check("sp_hold", RD_B, 8'hAA);

    WE = 1'b1; RW_addr = 2'd3; WD = 8'h00; tick(); idle();
    check("sp_zero", RD_B, 8'h00);
    DecSP = 1'b1; tick(); idle();
    check("sp_wrap_dn", RD_B, 8'hFF);
    IncSP = 1'b1; tick(); idle();
    check("sp_wrap_up", RD_B, 8'h00);
    WE = 1'b1; RW_addr = 2'd1; WD = 8'h5A; DecSP = 1'b1; RA_addr = 2'd1; tick(); idle();
    check("mixed_r1", RD_A, 8'h5A);
    check("mixed_sp", RD_B, 8'hFF);

    // forwarding vs. old value before the edge
    WE = 1'b1; RW_addr = 2'd2; WD = 8'h77; tick(); idle();
    WE = 1'b1; RW_addr = 2'd2; WD = 8'h3C; RA_addr = 2'd2; RB_addr = 2'd2; #1;
`ifdef REGFILE_BYPASS_EN
    exp_v = 8'h3C;
`else
    exp_v = 8'h77;
`endif
    check("pre_edge_a", RD_A, exp_v);
    check("pre_edge_b", RD_B, exp_v);
    tick(); idle();
    check("post_edge_a", RD_A, 8'h3C);

    RA_addr = 2'd3; IncSP = 1'b1; #1;
`ifdef REGFILE_BYPASS_EN
    exp_v = 8'h00;
`else
    exp_v = 8'hFF;
`endif
    check("sp_fwd", RD_A, exp_v);
    tick(); idle();
    check("sp_after_inc", RD_A, 8'h00);

    // reset overrides an in-flight write
    WE = 1'b1; RW_addr = 2'd1; WD = 8'hC3; DecSP = 1'b1; #2;
    rst = 1'b1; #1;
    check("midop_rst_r1", dut.file[1], 8'h00);
    check("midop_rst_sp", dut.file[3], 8'hFF);
    tick();
    check("rst_held_r2", dut.file[2], 8'h00);
    idle(); rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
